// File: rtl/idct_pkg.sv
// Shared types, default widths, cosine table and output rounding for the 8-point 1-D IDCT.
package idct_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC  = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam int IDCT_COEF_W = 16;
    localparam int IDCT_FRAC   = 14;

    // Entry [8*k + n] = round(2^14 * c(n)/2 * cos((2k+1)*n*pi/16)).
    localparam logic signed [IDCT_COEF_W-1:0] COS_TABLE [64] = '{
        16'sd5793,  16'sd8035,  16'sd7568,  16'sd6811,  16'sd5793,  16'sd4551,  16'sd3135,  16'sd1598,
        16'sd5793,  16'sd6811,  16'sd3135, -16'sd1598, -16'sd5793, -16'sd8035, -16'sd7568, -16'sd4551,
        16'sd5793,  16'sd4551, -16'sd3135, -16'sd8035, -16'sd5793,  16'sd1598,  16'sd7568,  16'sd6811,
        16'sd5793,  16'sd1598, -16'sd7568, -16'sd4551,  16'sd5793,  16'sd6811, -16'sd3135, -16'sd8035,
        16'sd5793, -16'sd1598, -16'sd7568,  16'sd4551,  16'sd5793, -16'sd6811, -16'sd3135,  16'sd8035,
        16'sd5793, -16'sd4551, -16'sd3135,  16'sd8035, -16'sd5793, -16'sd1598,  16'sd7568, -16'sd6811,
        16'sd5793, -16'sd6811,  16'sd3135,  16'sd1598, -16'sd5793,  16'sd8035, -16'sd7568,  16'sd4551,
        16'sd5793, -16'sd8035,  16'sd7568, -16'sd6811,  16'sd5793, -16'sd4551,  16'sd3135, -16'sd1598
    };

    // Round half up, arithmetic shift, then clamp to the signed output range
    // or, for pixel reconstruction, level-shift by 128 and clamp to 0..255.
    function automatic longint sat_round(input longint acc, input int frac,
                                         input int out_w, input bit level_shift);
        longint v;
        longint lo;
        longint hi;
        v = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        if (level_shift) begin
            v  = v + 64'sd128;
            lo = 64'sd0;
            hi = 64'sd255;
        end else begin
            lo = -(64'sd1 <<< (out_w - 1));
            hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        end
        if (v < lo) v = lo;
        if (v > hi) v = hi;
        return v;
    endfunction

endpackage

// File: rtl/idct8_cos_rom.sv
// Combinational cosine lookup C[k][n] for the IDCT MAC.
module idct8_cos_rom
    import idct_pkg::*;
(
    input  logic [2:0]                    k,
    input  logic [2:0]                    n,
    output logic signed [IDCT_COEF_W-1:0] coef
);

    assign coef = COS_TABLE[{k, n}];

endmodule

// File: rtl/idct8_1d.sv
// Streaming 8-point 1-D IDCT with one time-multiplexed MAC.
// Define IDCT_LEVEL_SHIFT_EN to emit clamp(x+128, 0, 255) pixels instead of signed samples.
module idct8_1d
    import idct_pkg::*;
#(
    parameter int IN_W   = 12,
    parameter int OUT_W  = 9,
    parameter int COEF_W = IDCT_COEF_W,
    parameter int FRAC   = IDCT_FRAC,
    parameter int ACC_W  = IN_W + COEF_W + 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_last
);

`ifdef IDCT_LEVEL_SHIFT_EN
    localparam bit LEVEL_SHIFT = 1'b1;
`else
    localparam bit LEVEL_SHIFT = 1'b0;
`endif

    state_t                        state;
    state_t                        state_nx;
    logic                          armed;
    logic [2:0]                    n_idx;
    logic [2:0]                    k_idx;
    logic signed [IN_W-1:0]        x_reg [8];
    logic signed [ACC_W-1:0]       acc;
    logic signed [IDCT_COEF_W-1:0] rom_coef;
    logic signed [COEF_W-1:0]      coef;
    logic signed [IN_W+COEF_W-1:0] prod;
    longint                        sample;
    logic                          accept;

    idct8_cos_rom u_rom (
        .k    (k_idx),
        .n    (n_idx),
        .coef (rom_coef)
    );

    assign coef   = COEF_W'(rom_coef);
    assign prod   = x_reg[n_idx] * coef;
    assign accept = in_valid && in_ready;

    // in_ready stays low for the first cycle out of reset so LOAD starts on the first edge.
    assign in_ready  = armed && (state == LOAD);
    assign out_valid = (state == EMIT);
    assign out_last  = out_valid && (k_idx == 3'd7);
    assign sample    = sat_round(longint'(acc), FRAC, OUT_W, LEVEL_SHIFT);
    assign out_data  = out_valid ? sample[OUT_W-1:0] : '0;

    always_comb begin
        state_nx = state;
        case (state)
            LOAD: if (accept && n_idx == 3'd7) state_nx = MAC;
            MAC:  if (n_idx == 3'd7) state_nx = EMIT;
            EMIT: if (out_ready) state_nx = (k_idx == 3'd7) ? LOAD : MAC;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            armed <= 1'b0;
            n_idx <= 3'd0;
            k_idx <= 3'd0;
            acc   <= '0;
            for (int i = 0; i < 8; i++) x_reg[i] <= '0;
        end else begin
            armed <= 1'b1;
            state <= state_nx;
            case (state)
                LOAD: begin
                    if (accept) begin
                        x_reg[n_idx] <= in_data;
                        n_idx        <= n_idx + 3'd1;
                        k_idx        <= 3'd0;
                        acc          <= '0;
                    end
                end
                MAC: begin
                    acc   <= acc + ACC_W'(prod);
                    n_idx <= n_idx + 3'd1;
                end
                EMIT: begin
                    // acc is left untouched while stalled so out_data holds.
                    if (out_ready && k_idx != 3'd7) begin
                        k_idx <= k_idx + 3'd1;
                        acc   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
